time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000, cycles a raw button level must stay stable to be accepted (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYC, default 25000000, cycles btn_inc must be held before auto-repeat starts.
REQ-003 Parameter REPEAT_CYC, default 12500000, auto-repeat increment period.
REQ-004 Parameter TIMEOUT_CYC, default 1500000000, idle cycles in a set state before the edit is abandoned.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst  input  1  reset, synchronous, active-high; clock clk.
REQ-007 btn_mode_n  input  1  raw asynchronous mode button, active-low.
REQ-008 btn_inc_n  input  1  raw asynchronous increment button, active-low.
REQ-009 cur_hh_bcd  input  8  running hours from the time counters, {tens,units} BCD.
REQ-010 cur_mm_bcd  input  8  running minutes, {tens,units} BCD.
REQ-011 set_active  output  1  high in SET_HH/SET_MM; time counters hold while high.
REQ-012 blink_sel  output  2  display blink field: 00 none, 01 hours, 10 minutes.
REQ-013 load  output  1  single-cycle pulse; counters load load_hh_bcd/load_mm_bcd and clear seconds.
REQ-014 load_hh_bcd  output  8  edited hours, BCD.
REQ-015 load_mm_bcd  output  8  edited minutes, BCD.

Function
REQ-016 Each button SHALL pass a 2-FF synchronizer, then a debouncer updating its level only after DEBOUNCE_CYC consecutive identical samples.
REQ-017 A press SHALL be a one-cycle pulse on the debounced inactive-to-active transition; releases generate nothing.
REQ-018 FSM states RUN, SET_HH, SET_MM, COMMIT; RUN after reset.
REQ-019 RUN: mode press -> SET_HH, capturing cur_hh_bcd/cur_mm_bcd into edit registers that cycle; inc ignored.
REQ-020 SET_HH: inc press -> hours +1 BCD, 23 wraps to 00; mode press -> SET_MM.
REQ-021 SET_MM: inc press -> minutes +1 BCD, 59 wraps to 00; mode press -> COMMIT.
REQ-022 COMMIT: lasts exactly one cycle, load=1, then RUN unconditionally.
REQ-023 BCD increment: units 9 -> 0 with tens +1; no non-BCD value ever on load_*_bcd.
REQ-024 A captured field with invalid BCD or out of range (hh>23, mm>59) SHALL be replaced by 00.
REQ-025 Auto-repeat: in SET_HH/SET_MM with debounced inc held, first extra increment HOLD_CYC cycles after press, then every REPEAT_CYC cycles until release or state change.
REQ-026 Mode and inc press in the same cycle: mode acts, inc discarded.
REQ-027 Idle timer counts in SET_HH/SET_MM, cleared on any press or repeat; reaching TIMEOUT_CYC -> RUN with no load pulse, edit discarded.
REQ-028 blink_sel = 01 in SET_HH, 10 in SET_MM, 00 otherwise; set_active high only in SET_HH/SET_MM.
REQ-029 load_hh_bcd/load_mm_bcd SHALL equal the edit registers at all times.
REQ-030 Buttons held through a state change SHALL NOT generate a new press until released and re-pressed.

Reset
REQ-031 On rst: state RUN, load=0, set_active=0, blink_sel=00, edit registers 00/00, debounced levels released, all timers 0.
REQ-032 rst mid-edit SHALL abandon the edit without load; rst overrides all other events in that cycle.

Structure
REQ-033 Shared package time_set_pkg SHALL hold the state enum, HH_MAX_BCD=8'h23, MM_MAX_BCD=8'h59 and the BCD-increment function.
REQ-034 Sub-module btn_debounce (synchronizer, debouncer, press pulse) SHALL be instantiated once per button.

Verification (bench uses DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8, TIMEOUT_CYC=100)
REQ-035 Glitch: btn_mode_n low 3 cycles -> no state change; low 10 cycles -> SET_HH, blink_sel=01, edit=cur value (e.g. 14:37).
REQ-036 Full edit from 14:37: 10 inc presses in SET_HH -> hh 00 (wraps after 23); mode; 23 inc -> mm 00; mode -> one load pulse, outputs 00:00, back to RUN.
REQ-037 Auto-repeat: inc held 60 debounced cycles in SET_MM at 58 -> increments at +20, +28, +36, +44, +52 -> 59,00,01,02,03.
REQ-038 Timeout: enter SET_HH, no presses 100 cycles -> RUN, load never asserted, set_active=0.
REQ-039 Simultaneous mode+inc press in SET_HH at 09 -> SET_MM, hours remain 09.
REQ-040 rst asserted in SET_MM, then capture cur 2A:75 -> all reset values, no load; capture yields 00:00.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared definitions for the time-setting controller: FSM state type,
// BCD range limits and the BCD helpers used on the edit registers.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] HH_MAX_BCD = 8'h23;
  localparam logic [7:0] MM_MAX_BCD = 8'h59;

  // True when both nibbles are decimal digits and the value is within max.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Captured values that are not usable BCD in range restart from 00.
  function automatic logic [7:0] bcd_capture(input logic [7:0] v, input logic [7:0] max);
    return bcd_valid(v, max) ? v : 8'h00;
  endfunction

  // +1 in BCD; max wraps to 00. Input is always a valid in-range value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v >= max)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-FF synchronizer, debouncer and press pulse.
//   clk, rst : clock, synchronous active-high reset
//   btn_n    : raw asynchronous button, active-low
//   level    : debounced button level, active-high (1 = pressed)
//   press    : one-cycle pulse on the debounced released->pressed edge
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1, sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      level_q <= level;
      // cnt counts consecutive samples disagreeing with the current level
      if (~sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-setting controller. Two buttons (mode, inc) walk through
// RUN -> SET_HH -> SET_MM -> COMMIT, editing a captured copy of the running
// time with BCD increments, auto-repeat on a held inc, and an idle timeout.
//   clk, rst         : clock, synchronous active-high reset
//   btn_mode_n       : raw mode button, active-low
//   btn_inc_n        : raw increment button, active-low
//   cur_hh_bcd/mm    : running time, BCD
//   set_active       : high while editing (counters hold)
//   blink_sel        : 00 none, 01 hours, 10 minutes
//   load             : one-cycle pulse, counters take load_hh_bcd/load_mm_bcd
//   load_hh/mm_bcd   : edit registers
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 12500000,
  parameter int unsigned TIMEOUT_CYC  = 1500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [7:0] cur_hh_bcd,
  input  logic [7:0] cur_mm_bcd,
  output logic       set_active,
  output logic [1:0] blink_sel,
  output logic       load,
  output logic [7:0] load_hh_bcd,
  output logic [7:0] load_mm_bcd
);

  localparam int unsigned RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

  state_t          state, state_nxt;
  logic            mode_lvl, mode_press, inc_lvl, inc_press;
  logic [7:0]      edit_hh, edit_mm;
  logic [RW-1:0]   rep_cnt;
  logic            rep_armed, rep_first, rep_fire;
  logic [TW-1:0]   idle_cnt;
  logic            in_set, inc_evt, timeout;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_mode_n),
    .level (mode_lvl),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_inc_n),
    .level (inc_lvl),
    .press (inc_press)
  );

  assign in_set   = (state == SET_HH) || (state == SET_MM);
  assign rep_fire = in_set & rep_armed & inc_lvl &
                    (rep_cnt == (rep_first ? RW'(HOLD_CYC - 1) : RW'(REPEAT_CYC - 1)));
  // mode wins over a coincident inc press or repeat
  assign inc_evt  = in_set & ~mode_press & (inc_press | rep_fire);
  assign timeout  = in_set & ~mode_press & ~inc_evt & (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    set_active = 1'b0;
    blink_sel  = 2'b00;
    load       = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) state_nxt = SET_HH;
      end
      SET_HH: begin
        set_active = 1'b1;
        blink_sel  = 2'b01;
        if (mode_press)   state_nxt = SET_MM;
        else if (timeout) state_nxt = RUN;
      end
      SET_MM: begin
        set_active = 1'b1;
        blink_sel  = 2'b10;
        if (mode_press)   state_nxt = COMMIT;
        else if (timeout) state_nxt = RUN;
      end
      COMMIT: begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edit_hh   <= '0;
      edit_mm   <= '0;
      idle_cnt  <= '0;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_first <= 1'b0;
    end else begin
      if (state == RUN && mode_press) begin
        edit_hh <= bcd_capture(cur_hh_bcd, HH_MAX_BCD);
        edit_mm <= bcd_capture(cur_mm_bcd, MM_MAX_BCD);
      end else if (inc_evt) begin
        if (state == SET_HH) edit_hh <= bcd_inc(edit_hh, HH_MAX_BCD);
        else                 edit_mm <= bcd_inc(edit_mm, MM_MAX_BCD);
      end

      if (!in_set || mode_press || inc_evt || timeout) idle_cnt <= '0;
      else                                             idle_cnt <= idle_cnt + TW'(1);

      // Repeat only follows a press accepted in the current set state, so a
      // button held across a state change never repeats in the new state.
      if (!in_set || mode_press || !inc_lvl) begin
        rep_armed <= 1'b0;
        rep_cnt   <= '0;
      end else if (inc_press) begin
        rep_armed <= 1'b1;
        rep_first <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_fire) begin
        rep_first <= 1'b0;
        rep_cnt   <= '0;
      end else if (rep_armed) begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

  assign load_hh_bcd = edit_hh;
  assign load_mm_bcd = edit_mm;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with short timing parameters. A behavioural model
// (sample-window debounce, decimal time arithmetic, cycle-stamp timers) is
// compared against every output on every cycle; directed scenarios add
// constant checks at the interesting points.
module tb_time_set_ctrl;

  localparam int unsigned DB = 4, HOLD = 20, REP = 8, TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode_n = 1'b1, btn_inc_n = 1'b1;
  logic [7:0] cur_hh_bcd = 8'h14, cur_mm_bcd = 8'h37;
  logic       set_active, load;
  logic [1:0] blink_sel;
  logic [7:0] load_hh_bcd, load_mm_bcd;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEBOUNCE_CYC(DB),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode_n (btn_mode_n),
    .btn_inc_n  (btn_inc_n),
    .cur_hh_bcd (cur_hh_bcd),
    .cur_mm_bcd (cur_mm_bcd),
    .set_active (set_active),
    .blink_sel  (blink_sel),
    .load       (load),
    .load_hh_bcd(load_hh_bcd),
    .load_mm_bcd(load_mm_bcd)
  );

  int total = 0, bad = 0, loads = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [5:0] hm = '1, hi = '1;     // raw sample history, [0] newest
  bit  lm = 0, lm_q = 0, li = 0, li_q = 0;
  int  phase = 0;                   // 0 running, 1 hours, 2 minutes, 3 commit
  int  hh = 0, mm = 0, cyc = 0, last = 0, rep_base = -1;

  function automatic int cap(input logic [7:0] v, input int max);
    int n;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 0;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (n > max) ? 0 : n;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hm = '1; hi = '1; lm = 0; lm_q = 0; li = 0; li_q = 0;
      phase = 0; hh = 0; mm = 0; cyc = 0; last = 0; rep_base = -1;
    end else begin
      bit pm, pi, rep;
      int d;
      cyc++;
      pm  = lm & ~lm_q;
      pi  = li & ~li_q;
      d   = cyc - rep_base;
      rep = (phase == 1 || phase == 2) && li && rep_base >= 0 &&
            (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0));
      case (phase)
        0: if (pm) begin
             hh = cap(cur_hh_bcd, 23); mm = cap(cur_mm_bcd, 59);
             phase = 1; last = cyc;
           end
        1, 2: begin
          if (pm) begin
            phase++; last = cyc; rep_base = -1;
          end else if (pi || rep) begin
            if (phase == 1) hh = (hh + 1) % 24;
            else            mm = (mm + 1) % 60;
            last = cyc;
            if (pi) rep_base = cyc;
          end else if (cyc - last == TO) begin
            phase = 0; rep_base = -1;
          end
        end
        default: phase = 0;
      endcase
      if (!li) rep_base = -1;
      // debounce: accept a level once the 4 samples behind the
      // synchronizer all disagree with it
      hm = {hm[4:0], btn_mode_n};
      hi = {hi[4:0], btn_inc_n};
      lm_q = lm; li_q = li;
      if (hm[5:2] == 4'b0000) lm = 1; else if (hm[5:2] == 4'b1111) lm = 0;
      if (hi[5:2] == 4'b0000) li = 1; else if (hi[5:2] == 4'b1111) li = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (load === 1'b1) loads++;
    check("set_active", set_active, (phase == 1 || phase == 2));
    check("blink_sel", blink_sel, (phase == 1) ? 2'b01 : (phase == 2) ? 2'b10 : 2'b00);
    check("load", load, (phase == 3));
    check("load_hh", load_hh_bcd, to_bcd(hh));
    check("load_mm", load_mm_bcd, to_bcd(mm));
  endtask

  task automatic drive(input logic m, input logic i, input int n);
    btn_mode_n = m;
    btn_inc_n  = i;
    repeat (n) tick();
  endtask

  task automatic press_mode();
    drive(1'b0, 1'b1, 8);
    drive(1'b1, 1'b1, 10);
  endtask

  task automatic press_inc();
    drive(1'b1, 1'b0, 8);
    drive(1'b1, 1'b1, 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_set_active"}, set_active, 1'b0);
    check({tag, "_blink"}, blink_sel, 2'b00);
    check({tag, "_load"}, load, 1'b0);
    check({tag, "_hh"}, load_hh_bcd, 8'h00);
    check({tag, "_mm"}, load_mm_bcd, 8'h00);
  endtask

  initial begin
    int lc;
    drive(1'b1, 1'b1, 3);
    check_reset_outputs("rst");
    rst = 1'b0;
    drive(1'b1, 1'b1, 4);

    // glitch rejected, then a real press enters hour setting
    drive(1'b0, 1'b1, 3);
    drive(1'b1, 1'b1, 15);
    check("glitch_blink", blink_sel, 2'b00);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 12);
    check("enter_blink", blink_sel, 2'b01);
    check("enter_hh", load_hh_bcd, 8'h14);
    check("enter_mm", load_mm_bcd, 8'h37);

    // full edit with wraps
    for (int k = 0; k < 10; k++) press_inc();
    check("hh_wrap", load_hh_bcd, 8'h00);
    press_mode();
    check("mm_blink", blink_sel, 2'b10);
    for (int k = 0; k < 23; k++) press_inc();
    check("mm_wrap", load_mm_bcd, 8'h00);
    lc = loads;
    press_mode();
    check("commit_loads", loads, lc + 1);
    check("commit_hh", load_hh_bcd, 8'h00);
    check("commit_mm", load_mm_bcd, 8'h00);
    check("commit_run", set_active, 1'b0);

    // auto-repeat: press 57->58, then 59,00,01,02,03 on repeats
    cur_mm_bcd = 8'h57;
    press_mode();
    press_mode();
    drive(1'b1, 1'b0, 60);
    drive(1'b1, 1'b1, 12);
    check("repeat_mm", load_mm_bcd, 8'h03);
    check("repeat_hh", load_hh_bcd, 8'h14);
    lc = loads;
    press_mode();
    check("repeat_commit", loads, lc + 1);

    // timeout discards the edit
    lc = loads;
    press_mode();
    drive(1'b1, 1'b1, 70);
    check("pre_timeout", set_active, 1'b1);
    drive(1'b1, 1'b1, 30);
    check("timeout_active", set_active, 1'b0);
    check("timeout_noload", loads, lc);

    // simultaneous mode+inc in hour setting
    cur_hh_bcd = 8'h09;
    press_mode();
    drive(1'b0, 1'b0, 8);
    drive(1'b1, 1'b1, 10);
    check("simul_blink", blink_sel, 2'b10);
    check("simul_hh", load_hh_bcd, 8'h09);

    // reset mid-edit, then capture of invalid values
    lc = loads;
    rst = 1'b1;
    drive(1'b1, 1'b1, 2);
    check_reset_outputs("midrst");
    rst = 1'b0;
    cur_hh_bcd = 8'h2A;
    cur_mm_bcd = 8'h75;
    press_mode();
    check("inval_blink", blink_sel, 2'b01);
    check("inval_hh", load_hh_bcd, 8'h00);
    check("inval_mm", load_mm_bcd, 8'h00);
    check("midrst_noload", loads, lc);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      int r;
      cur_hh_bcd = ($urandom_range(0, 3) != 0) ? to_bcd($urandom_range(0, 23)) : 8'($urandom);
      cur_mm_bcd = ($urandom_range(0, 3) != 0) ? to_bcd($urandom_range(0, 59)) : 8'($urandom);
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2: begin
          drive(1'b0, 1'b1, $urandom_range(1, 12));
          drive(1'b1, 1'b1, $urandom_range(1, 12));
        end
        3, 4, 5, 6: begin
          drive(1'b1, 1'b0, $urandom_range(1, 50));
          drive(1'b1, 1'b1, $urandom_range(1, 12));
        end
        7: begin
          drive(1'b0, 1'b0, $urandom_range(4, 12));
          drive(1'b1, 1'b1, $urandom_range(4, 12));
        end
        8: drive(1'b1, 1'b1, $urandom_range(1, 120));
        9: begin
          drive(1'b1, 1'b0, 10);
          drive(1'b0, 1'b0, 8);
          drive(1'b1, 1'b0, $urandom_range(5, 40));
          drive(1'b1, 1'b1, 8);
        end
        10: begin
          rst = 1'b1;
          drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 3));
          rst = 1'b0;
        end
        default: begin
          btn_mode_n = 1'b1;
          for (int k = 0; k < 12; k++) drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end
      endcase
    end
    drive(1'b1, 1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
